unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
// - Shares one single-port, variable-latency memory between the IF-stage instruction fetch port
//   (read-only) and the MEM-stage data port (read/write) of the five-stage CPU.
// - Fixed priority to data (the older instruction), with an anti-starvation override for fetch.
// - Registered req/ack handshake per requester; bus timeout with error flag; per-port stall outputs.
// PARAMETERS
// - AW        7    word-address width (matches pc[8:2] / alurslt[8:2])
// - DW        32   data width
// - MAX_WAIT  4    fetch requests lost to data this many times in a row -> fetch wins the next arbitration
// - TIMEOUT   16   BUSY cycles without mem_ready before abort; >=2
// PORTS
// - clk        in   1    clock, all state on posedge
// - reset_n    in   1    asynchronous, active-low reset
// - i_req      in   1    fetch request; held with i_addr until i_ack
// - i_addr     in   AW   fetch word address
// - i_ack      out  1    one-cycle pulse; i_rdata/i_err valid this cycle
// - i_rdata    out  DW   fetched instruction
// - i_err      out  1    fetch aborted by timeout (valid with i_ack)
// - d_req      in   1    data request; held with d_we/d_addr/d_wdata until d_ack
// - d_we       in   1    1=write, 0=read
// - d_addr     in   AW   data word address
// - d_wdata    in   DW   store data
// - d_ack      out  1    one-cycle pulse; d_rdata/d_err valid this cycle
// - d_rdata    out  DW   load data (0 on write or error)
// - d_err      out  1    data access aborted by timeout
// - stall_if   out  1    i_req & ~i_ack (comb.); freezes PC/IF-ID
// - stall_mem  out  1    d_req & ~d_ack (comb.); freezes whole pipe
// - mem_en     out  1    memory access strobe, held through BUSY
// - mem_we     out  1    memory write enable (only with mem_en)
// - mem_addr   out  AW   memory address
// - mem_wdata  out  DW   memory write data
// - mem_rdata  in   DW   memory read data, valid when mem_ready
// - mem_ready  in   1    access complete this cycle
// BEHAVIOUR
// - FSM states: IDLE, BUSY_I, BUSY_D, ACK. Arbitration happens only in IDLE.
//   - IDLE: d_req & !(i_req & starve) -> BUSY_D; else i_req -> BUSY_I; else stay.
//     - starve = (wait_cnt == MAX_WAIT).
//   - BUSY_x: mem_en=1. Address, we and wdata are latched at the IDLE->BUSY edge and held constant.
//     mem_ready=1 -> ACK (rdata captured); timeout -> ACK with err.
//   - ACK: exactly one of i_ack/d_ack=1 for the granted port; mem_en=0; -> IDLE unconditionally.
//     No requests are sampled in ACK. The requester must drop req or present its next request by the following cycle.
// - Latency: req seen at cycle 0 in IDLE; BUSY at 1; mem_ready at cycle k>=1; ack at k+1.
//   Best case 2 cycles, 3-cycle minimum spacing between grants.
// - wait_cnt (width clog2(MAX_WAIT+1)):
//   - +1 on each IDLE grant to D while i_req=1, saturating at MAX_WAIT.
//   - Cleared on any grant to I.
// - timeout counter: cleared on entry to BUSY; +1 per BUSY cycle with mem_ready=0.
//   Reaching TIMEOUT-1 without ready -> abort: err=1, rdata=0, mem_en dropped.
// - Write: mem_we=1 only in BUSY_D with latched d_we=1. d_rdata=0 on the write ack.
// - Simultaneous i_req & d_req in IDLE, not starved -> D first; I granted in the next IDLE.
// - mem_ready while not BUSY is ignored. mem_rdata is sampled only in BUSY on mem_ready.
// - Reset (asynchronous, any state, including mid-BUSY):
//   - state=IDLE.
//   - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, acks, errs, rdata.
//   - wait_cnt=0, timeout counter=0.
//   - An in-flight access is dropped, with no ack.
// - Arithmetic is unsigned; counters never wrap.
// TESTING
// - I only, mem_ready 1 cycle after mem_en, i_addr=7'h05, mem_rdata=32'h2002000A
//   -> i_ack at cycle 2 with i_rdata=32'h2002000A, mem_we=0.
// - i_req & d_req together, d_we=1, d_addr=7'h10, d_wdata=32'hDEADBEEF
//   -> D granted first: mem_we=1, addr 7'h10, wdata DEADBEEF; d_ack, then I granted next IDLE.
// - d_req held continuously with back-to-back ops, i_req held, MAX_WAIT=4
//   -> 4 D grants, then I granted; wait_cnt cleared to 0.
// - mem_ready held 0, TIMEOUT=16
//   -> ack with err=1 and rdata=0 at BUSY cycle 16; mem_en low in ACK.
// - reset_n pulled low mid-BUSY_D -> same cycle all outputs 0, state IDLE;
//   after release, a new i_req completes normally.
// - Check stall_if/stall_mem track req&~ack each cycle; no ack issued without a prior req.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and the data port: data has priority, fetch gets an anti-starvation override.
module unified_mem_arbiter #(
    parameter int AW       = 7,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int TCW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_ACK
    } state_t;

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [TCW-1:0] r_tmo_cnt;

    logic w_starve;
    logic w_gnt_d;
    logic w_tmo_hit;
    logic w_busy;

    assign w_starve  = (r_wait_cnt == WCW'(MAX_WAIT));
    assign w_gnt_d   = d_req & ~(i_req & w_starve);
    // The cycle that would bring the count to TIMEOUT-1 is the abort cycle.
    assign w_tmo_hit = (r_tmo_cnt == TCW'(TIMEOUT - 2));
    assign w_busy    = (r_state == S_BUSY_I) | (r_state == S_BUSY_D);

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_tmo_cnt  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_d) begin
                        r_state   <= S_BUSY_D;
                        r_tmo_cnt <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (i_req && !w_starve)
                            r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end else if (i_req) begin
                        r_state    <= S_BUSY_I;
                        r_tmo_cnt  <= '0;
                        r_wait_cnt <= '0;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_wdata  <= '0;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (mem_ready || w_tmo_hit) begin
                        r_state <= S_ACK;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_state == S_BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_err   <= ~mem_ready;
                            i_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= ~mem_ready;
                            d_rdata <= (mem_ready && !mem_we) ?
                                       mem_rdata : '0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TCW'(1);
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Only meaningful as an internal consistency hint; mem_en tracks BUSY.
    logic w_unused;
    assign w_unused = w_busy;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_unified_mem_arbiter;

    localparam int AW       = 7;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    unified_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .d_err(d_err), .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          ir;
        bit          dr;
        bit          we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        bit          exp_d;
        int          exp_cyc;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic check_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_acks"}, {i_ack, d_ack}, 0);
        chk({tag, "_errs"}, {i_err, d_err}, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          got_c;
        bit          got_d;
        logic [31:0] rd;
        logic        er;
        string       tg;
        got_c = -1;
        got_d = 1'b0;
        rd    = '0;
        er    = 1'b0;
        tg    = $sformatf("vec%0d", idx);
        d_req = v.dr; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        i_req = v.ir; i_addr = v.addr;
        #1;
        for (int c = 0; c <= 40; c++) begin
            if (c <= v.exp_cyc) begin
                chk({tg, "_mem_en"}, mem_en, (c >= 1 && c < v.exp_cyc));
                chk({tg, "_stall_if"}, stall_if,
                    v.ir && !(c == v.exp_cyc && !v.exp_d));
                chk({tg, "_stall_mem"}, stall_mem,
                    v.dr && !(c == v.exp_cyc && v.exp_d));
            end
            if (c == 1) begin
                chk({tg, "_mem_we"}, mem_we, v.we & v.dr);
                chk({tg, "_mem_addr"}, mem_addr, v.addr);
            end
            if (i_ack || d_ack) begin
                got_c = c;
                got_d = d_ack;
                rd    = d_ack ? d_rdata : i_rdata;
                er    = d_ack ? d_err : i_err;
                break;
            end
            mem_ready = (v.lat != 0 && c == v.lat);
            mem_rdata = mem_ready ? v.rdata : $urandom;
            tick();
        end
        chk({tg, "_ack_cycle"}, got_c, v.exp_cyc);
        chk({tg, "_ack_port"}, got_d, v.exp_d);
        chk({tg, "_rdata"}, rd, v.exp_rd);
        chk({tg, "_err"}, er, v.exp_err);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    logic [31:0] m [128];
    bit          ip, dp, g_d, g_we, g_err;
    int          wc, g_t, g_lat, a_t, free_at;
    logic [6:0]  g_addr;
    logic [31:0] g_wd, g_rd;

    initial begin
        int dack_c, iack_c, nack;
        bit seq_d [10];
        int seq_c [10];
        logic [31:0] cap;

        vecs[0] = '{1, 0, 0, 7'h05, 0, 32'h2002000A, 1, 0, 2, 0, 32'h2002000A};
        vecs[1] = '{0, 1, 0, 7'h10, 0, 32'h12345678, 3, 1, 4, 0, 32'h12345678};
        vecs[2] = '{0, 1, 1, 7'h10, 32'hDEADBEEF, 32'h55AA55AA, 1, 1, 2, 0, 0};
        vecs[3] = '{1, 0, 0, 7'h22, 0, 32'hFFFFFFFF, 0, 0, 16, 1, 0};
        vecs[4] = '{0, 1, 0, 7'h7F, 0, 32'h0F0F0F0F, 15, 1, 16, 0, 32'h0F0F0F0F};
        vecs[5] = '{0, 1, 1, 7'h00, 32'h11112222, 32'h33334444, 0, 1, 16, 1, 0};
        vecs[6] = '{1, 0, 0, 7'h3C, 0, 32'hCAFEF00D, 7, 0, 8, 0, 32'hCAFEF00D};
        vecs[7] = '{1, 0, 0, 7'h41, 0, 32'h89ABCDEF, 16, 0, 16, 1, 0};

        reset_n = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
        #1;
        check_zero("reset");
        chk("reset_stalls", {stall_if, stall_mem}, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Simultaneous requests: data first, fetch in the next IDLE.
        dack_c = -1; iack_c = -1; cap = '0;
        d_req = 1; d_we = 1; d_addr = 7'h10; d_wdata = 32'hDEADBEEF;
        i_req = 1; i_addr = 7'h05; mem_rdata = 32'h13579BDF;
        #1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 1) begin
                chk("sim_mem_we_d", mem_we, 1);
                chk("sim_mem_addr_d", mem_addr, 7'h10);
                chk("sim_mem_wdata_d", mem_wdata, 32'hDEADBEEF);
            end
            if (c == 4) begin
                chk("sim_mem_addr_i", mem_addr, 7'h05);
                chk("sim_mem_we_i", mem_we, 0);
            end
            if (d_ack) begin
                dack_c = c;
                chk("sim_d_rdata", d_rdata, 0);
                d_req = 0;
            end
            if (i_ack) begin
                iack_c = c;
                cap = i_rdata;
                i_req = 0;
                break;
            end
            mem_ready = mem_en;
            tick();
        end
        chk("sim_dack_cycle", dack_c, 2);
        chk("sim_iack_cycle", iack_c, 5);
        chk("sim_i_rdata", cap, 32'h13579BDF);
        mem_ready = 0;
        tick();

        // Starvation: both held, data back-to-back.
        nack = 0;
        d_req = 1; d_we = 0; d_addr = 7'h11; i_req = 1; i_addr = 7'h22;
        for (int c = 0; c < 200 && nack < 10; c++) begin
            if (i_ack || d_ack) begin
                seq_d[nack] = d_ack;
                seq_c[nack] = c;
                nack++;
                if (d_ack) d_addr = 7'($urandom);
                else i_addr = 7'($urandom);
                if (nack == 10) begin
                    d_req = 0; i_req = 0;
                end
            end
            mem_ready = mem_en;
            tick();
        end
        chk("starve_ack_count", nack, 10);
        for (int k = 0; k < nack; k++) begin
            chk($sformatf("starve_port%0d", k), seq_d[k], (k % 5) != 4);
            if (k > 0)
                chk($sformatf("starve_gap%0d", k), seq_c[k] - seq_c[k-1], 3);
        end
        mem_ready = 0;
        tick();

        // Reset in the middle of a data write.
        d_req = 1; d_we = 1; d_addr = 7'h33; d_wdata = 32'hA5A5A5A5;
        tick(); tick(); tick();
        chk("rst_pre_mem_en", mem_en, 1);
        chk("rst_pre_mem_we", mem_we, 1);
        reset_n = 1'b0;
        #1;
        check_zero("rst_mid");
        d_req = 0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_post_idle", {mem_en, i_ack, d_ack}, 0);
        end
        iack_c = -1; cap = '0;
        i_req = 1; i_addr = 7'h05; mem_rdata = 32'h2002000A;
        #1;
        for (int c = 0; c <= 10; c++) begin
            if (i_ack) begin
                iack_c = c; cap = i_rdata; i_req = 0; break;
            end
            mem_ready = mem_en;
            tick();
        end
        chk("rst_after_iack_cycle", iack_c, 2);
        chk("rst_after_i_rdata", cap, 32'h2002000A);
        mem_ready = 0;
        tick();

        // Randomized run against a transaction-level model.
        for (int k = 0; k < 128; k++) m[k] = $urandom;
        ip = 0; dp = 0; wc = 0; g_t = -100; a_t = -100; free_at = 0;
        g_d = 0; g_we = 0; g_err = 0; g_addr = 0; g_wd = 0; g_rd = 0; g_lat = 0;
        for (int t = 0; t < 3000; t++) begin
            bit busy, busy2, ea_i, ea_d, rdy;
            busy = (t > g_t) && (t < a_t);
            ea_i = (t == a_t) && !g_d;
            ea_d = (t == a_t) && g_d;
            chk("rnd_i_ack", i_ack, ea_i);
            chk("rnd_d_ack", d_ack, ea_d);
            if (ea_i) begin
                chk("rnd_i_rdata", i_rdata, g_rd);
                chk("rnd_i_err", i_err, g_err);
            end
            if (ea_d) begin
                chk("rnd_d_rdata", d_rdata, g_rd);
                chk("rnd_d_err", d_err, g_err);
            end
            chk("rnd_mem_en", mem_en, busy);
            if (busy) begin
                chk("rnd_mem_addr", mem_addr, g_addr);
                chk("rnd_mem_we", mem_we, g_we);
                if (g_we) chk("rnd_mem_wdata", mem_wdata, g_wd);
            end else begin
                chk("rnd_mem_we_idle", mem_we, 0);
            end
            if (t == a_t) begin
                if (g_d) dp = 0; else ip = 0;
                if (g_d && g_we && !g_err) m[g_addr] = g_wd;
            end
            if (t < 2800) begin
                if (!ip && $urandom_range(0, 2) == 0) begin
                    ip = 1; i_addr = 7'($urandom);
                end
                if (!dp && $urandom_range(0, 2) == 0) begin
                    dp = 1; d_addr = 7'($urandom);
                    d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
                end
            end
            i_req = ip; d_req = dp;
            if (t >= free_at && (ip || dp)) begin
                if (dp && !(ip && wc == MAX_WAIT)) begin
                    g_d = 1; g_we = d_we; g_addr = d_addr; g_wd = d_wdata;
                    if (ip && wc < MAX_WAIT) wc++;
                end else begin
                    g_d = 0; g_we = 0; g_addr = i_addr; g_wd = 0;
                    wc = 0;
                end
                g_t   = t;
                g_lat = ($urandom_range(0, 9) == 0) ?
                        int'($urandom_range(14, 20)) : int'($urandom_range(1, 4));
                g_err = (g_lat + 1 > TIMEOUT);
                a_t   = t + ((g_lat + 1 < TIMEOUT) ? g_lat + 1 : TIMEOUT);
                g_rd  = (g_err || g_we) ? 32'h0 : m[g_addr];
                free_at = a_t + 1;
            end
            busy2 = (t > g_t) && (t < a_t);
            rdy = busy2 ? (t == g_t + g_lat) : ($urandom_range(0, 3) == 0);
            mem_ready = rdy;
            mem_rdata = (busy2 && rdy) ? m[g_addr] : $urandom;
            #1;
            chk("rnd_stall_if", stall_if, ip & ~ea_i);
            chk("rnd_stall_mem", stall_mem, dp & ~ea_d);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
